util_pulse_meas: RTL and testbench

Measures the high time and low time of a single-bit, already-synchronous, glitch-filtered level, such as the output of the team's glitch filter. Each complete high-then-low cycle produces one result on a valid/ready output. A timeout reports stuck levels. The block sits directly downstream of the filter and feeds register banks or capture FIFOs.

---
 rtl/util_pulse_meas.sv | 139 +++++++++++++
 tb/tb_util_pulse_meas.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/util_pulse_meas.sv
// Measures high/low phase lengths of a synchronous level; one result per high-then-low cycle, 1-cycle registered latency.
// One-deep output register: results that arrive while an unaccepted result is held are dropped and counted in ovr_cnt.
module util_pulse_meas #(
    parameter int CNT_W = 32,
    parameter int OVR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic [2:0]       meas_status,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [OVR_W-1:0] OVR_MAX  = '1;

    logic             sig_d;
    logic             rise;
    logic             fall;
    logic             tmo_en;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] lcnt, lcnt_nxt;
    logic             sat_h, sat_h_nxt;
    logic             sat_l, sat_l_nxt;
    logic             emit;
    logic [CNT_W-1:0] emit_high;
    logic [CNT_W-1:0] emit_low;
    logic [2:0]       emit_status;
    logic             load;

    assign rise   = sig_i & ~sig_d;
    assign fall   = ~sig_i & sig_d;
    assign tmo_en = (cfg_timeout != '0);

    // Edges take priority over the timeout compare in the same cycle.
    always_comb begin
        state_nxt   = state;
        hcnt_nxt    = hcnt;
        lcnt_nxt    = lcnt;
        sat_h_nxt   = sat_h;
        sat_l_nxt   = sat_l;
        emit        = 1'b0;
        emit_high   = hcnt;
        emit_low    = lcnt;
        emit_status = 3'b000;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    hcnt_nxt  = CNT_ONE;
                    sat_h_nxt = 1'b0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_nxt = ST_LOW;
                    lcnt_nxt  = CNT_ONE;
                    sat_l_nxt = 1'b0;
                end else if (tmo_en && hcnt == cfg_timeout) begin
                    emit        = 1'b1;
                    emit_low    = '0;
                    emit_status = {1'b1, 1'b0, sat_h};
                    state_nxt   = ST_IDLE;
                end else if (hcnt == CNT_MAX) begin
                    sat_h_nxt = 1'b1;
                end else begin
                    hcnt_nxt = hcnt + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    emit        = 1'b1;
                    emit_status = {1'b0, sat_l, sat_h};
                    state_nxt   = ST_HIGH;
                    hcnt_nxt    = CNT_ONE;
                    sat_h_nxt   = 1'b0;
                end else if (tmo_en && lcnt == cfg_timeout) begin
                    emit        = 1'b1;
                    emit_status = {1'b1, sat_l, sat_h};
                    state_nxt   = ST_IDLE;
                end else if (lcnt == CNT_MAX) begin
                    sat_l_nxt = 1'b1;
                end else begin
                    lcnt_nxt = lcnt + CNT_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load = emit && (!meas_valid || meas_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d       <= sig_i;
            state       <= ST_IDLE;
            hcnt        <= '0;
            lcnt        <= '0;
            sat_h       <= 1'b0;
            sat_l       <= 1'b0;
            meas_valid  <= 1'b0;
            meas_high   <= '0;
            meas_low    <= '0;
            meas_status <= 3'b000;
            ovr_cnt     <= '0;
        end else begin
            sig_d <= sig_i;
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            lcnt  <= lcnt_nxt;
            sat_h <= sat_h_nxt;
            sat_l <= sat_l_nxt;
            if (load) begin
                meas_valid  <= 1'b1;
                meas_high   <= emit_high;
                meas_low    <= emit_low;
                meas_status <= emit_status;
            end else if (meas_ready) begin
                meas_valid <= 1'b0;
            end
            // Held result stays untouched; only the drop count moves.
            if (emit && !load && ovr_cnt != OVR_MAX) begin
                ovr_cnt <= ovr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_util_pulse_meas.sv
// Directed bench for util_pulse_meas: 32-bit instance for most cases, 8-bit instance for counter saturation.
module tb_util_pulse_meas;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig;
    logic        rdy;
    logic [31:0] tmo;
    logic [7:0]  tmo8;

    logic        m_vld;
    logic [31:0] m_high, m_low;
    logic [2:0]  m_st;
    logic [15:0] m_ovr;

    logic        s_vld;
    logic [7:0]  s_high, s_low;
    logic [2:0]  s_st;
    logic [15:0] s_ovr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_vld;

    always #5 clk = ~clk;

    util_pulse_meas #(.CNT_W(32), .OVR_W(16)) dut (
        .clk(clk), .rst(rst), .sig_i(sig), .cfg_timeout(tmo),
        .meas_valid(m_vld), .meas_ready(rdy), .meas_high(m_high),
        .meas_low(m_low), .meas_status(m_st), .ovr_cnt(m_ovr)
    );

    util_pulse_meas #(.CNT_W(8), .OVR_W(16)) dut8 (
        .clk(clk), .rst(rst), .sig_i(sig), .cfg_timeout(tmo8),
        .meas_valid(s_vld), .meas_ready(rdy), .meas_high(s_high),
        .meas_low(s_low), .meas_status(s_st), .ovr_cnt(s_ovr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    // Drive one cycle of the level, then sample just after the clock edge.
    task automatic tick(input logic s);
        @(negedge clk);
        sig = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sig = 1'b1; rdy = 1'b1; tmo = 0; tmo8 = 0;
        tick(1); tick(1);
        check("rst_valid", m_vld, 0);
        check("rst_high", m_high, 0);
        check("rst_low", m_low, 0);
        check("rst_status", m_st, 0);
        check("rst_ovr", m_ovr, 0);
        rst = 1'b0;

        // Initial high level after reset is not measured.
        repeat (10) tick(1);
        repeat (3) tick(0);
        repeat (4) tick(1);
        repeat (5) tick(0);
        check("t1_no_early", m_vld, 0);
        tick(1);
        check("t1_valid", m_vld, 1);
        check("t1_high", m_high, 4);
        check("t1_low", m_low, 5);
        check("t1_status", m_st, 0);

        // 2 high / 3 low square wave, ready held high.
        tick(1);
        check("t2_accept", m_vld, 0);
        for (int k = 0; k < 3; k++) begin
            repeat (3) tick(0);
            tick(1);
            check("t2_valid", m_vld, 1);
            check("t2_high", m_high, 2);
            check("t2_low", m_low, 3);
            tick(1);
            check("t2_drain", m_vld, 0);
        end
        check("t2_ovr", m_ovr, 0);

        // Backpressure: first result held, two dropped, last period has 4 low.
        rst = 1'b1; tick(0); rst = 1'b0;
        rdy = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            tick(1);
            if (p >= 2) begin
                check("t3_hold_valid", m_vld, 1);
                check("t3_hold_high", m_high, 2);
                check("t3_hold_low", m_low, 3);
            end
            tick(1);
            repeat ((p == 4) ? 4 : 3) tick(0);
        end
        check("t3_ovr", m_ovr, 2);
        rdy = 1'b1;
        tick(1);
        check("t3_reload_valid", m_vld, 1);
        check("t3_reload_low", m_low, 4);
        check("t3_ovr_after", m_ovr, 2);

        // Reset during LOW with a held result.
        rdy = 1'b0;
        tick(1);
        tick(0);
        check("t6_pre_valid", m_vld, 1);
        rst = 1'b1; tick(0); rst = 1'b0;
        check("t6_valid", m_vld, 0);
        check("t6_high", m_high, 0);
        check("t6_low", m_low, 0);
        check("t6_status", m_st, 0);
        check("t6_ovr", m_ovr, 0);
        tick(0);
        tick(1);
        check("t6_rise_no_result", m_vld, 0);
        tick(0);
        tick(1);
        check("t6_min_valid", m_vld, 1);
        check("t6_min_high", m_high, 1);
        check("t6_min_low", m_low, 1);

        // High-side timeout at 8 cycles.
        rdy = 1'b1;
        rst = 1'b1; tick(0); rst = 1'b0;
        tmo = 8;
        tick(0); tick(0);
        tick(1);
        repeat (7) tick(1);
        check("t4_before_tmo", m_vld, 0);
        tick(1);
        check("t4_valid", m_vld, 1);
        check("t4_high", m_high, 8);
        check("t4_low", m_low, 0);
        check("t4_status", m_st, 3'b100);
        n_vld = 0;
        repeat (20) begin tick(1); n_vld += int'(m_vld); end
        repeat (2) begin tick(0); n_vld += int'(m_vld); end
        tick(1); n_vld += int'(m_vld);
        check("t4_idle_quiet", n_vld, 0);
        tick(0);
        tick(1);
        check("t4_fresh_valid", m_vld, 1);

        // Low-side timeout: 3 high, then stuck low.
        tick(1); tick(1);
        repeat (8) tick(0);
        check("t4l_before_tmo", m_vld, 0);
        tick(0);
        check("t4l_valid", m_vld, 1);
        check("t4l_high", m_high, 3);
        check("t4l_low", m_low, 8);
        check("t4l_status", m_st, 3'b100);

        // Counter saturation on the 8-bit instance.
        tmo = 0;
        rst = 1'b1; tick(0); rst = 1'b0;
        tick(0);
        repeat (300) tick(1);
        repeat (2) tick(0);
        tick(1);
        check("t5_valid8", s_vld, 1);
        check("t5_high8", s_high, 255);
        check("t5_low8", s_low, 2);
        check("t5_status8", s_st, 3'b001);
        check("t5_high32", m_high, 300);
        check("t5_status32", m_st, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
